// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle controller.
// State encoding, opcode map and PC-source select codes.
package controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_JUMP   = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_JZ   = 4'b1100;
  localparam logic [3:0] OP_JNZ  = 4'b1101;
  localparam logic [3:0] OP_JC   = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] JS_PC1 = 3'b000;
  localparam logic [2:0] JS_JMP = 3'b001;
  localparam logic [2:0] JS_JZ  = 3'b010;
  localparam logic [2:0] JS_JNZ = 3'b011;
  localparam logic [2:0] JS_JC  = 3'b100;

  function automatic logic is_alu(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ) ||
           (op == OP_JNZ) || (op == OP_JC);
  endfunction

  function automatic logic [2:0] jsel_of(input logic [3:0] op);
    logic [2:0] js;
    js = JS_PC1;
    case (op)
      OP_JMP:  js = JS_JMP;
      OP_JZ:   js = JS_JZ;
      OP_JNZ:  js = JS_JNZ;
      OP_JC:   js = JS_JC;
      default: js = JS_PC1;
    endcase
    return js;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int OPCODE_W = 4
);
  logic                enable;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                mem_req;
  logic                enable_registers;
  logic                pc_load;
  logic                ir_load;
  logic                st_mux_s;
  logic                rf_load;
  logic                flag_load;
  logic                ld_mux_s;
  logic                data_memo_str;
  logic [2:0]          jump_select;
  logic                halted;
  logic                illegal;
  logic                timeout_err;

  modport master (
    input  enable, opcode, mem_ready,
    output mem_req, enable_registers, pc_load, ir_load,
    output st_mux_s, rf_load, flag_load, ld_mux_s,
    output data_memo_str, jump_select,
    output halted, illegal, timeout_err
  );

  modport slave (
    output enable, opcode, mem_ready,
    input  mem_req, enable_registers, pc_load, ir_load,
    input  st_mux_s, rf_load, flag_load, ld_mux_s,
    input  data_memo_str, jump_select,
    input  halted, illegal, timeout_err
  );
endinterface

// File: rtl/multicycle_controller_wait_timer.sv
// Memory wait counter with clear, increment and last-count flag.
// MEM_TIMEOUT of 0 never raises at_last.
module ctrl_wait_timer #(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  localparam logic [TIMEOUT_W-1:0] LAST =
    TIMEOUT_W'(MEM_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt;

  // count consecutive wait cycles, cleared on FETCH/MEM entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

  // one more wait from here would reach the limit
  assign at_last = (MEM_TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM with memory handshake,
// wait timeout and sticky halt/error states.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_e state, state_nxt;

  logic [OPCODE_W-1:0] opc;
  logic [3:0]          op;
  logic                op_bad;
  logic                run;
  logic                w_inc, w_clr, w_last;
  logic                set_ill, set_tmo;
  logic                ill_q, tmo_q;
  logic                d_exec, d_mem, d_jump, d_halt;

  assign opc    = bus.opcode;
  assign op     = opc[3:0];
  assign op_bad = |(opc >> 4);
  assign run    = bus.enable & ~rst;

  assign d_exec = ~op_bad & (is_alu(op) | (op == OP_MOV));
  assign d_mem  = ~op_bad & ((op == OP_LD) | (op == OP_ST));
  assign d_jump = ~op_bad & is_jump(op);
  assign d_halt = ~op_bad & (op == OP_HALT);

  ctrl_wait_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .inc    (w_inc),
    .at_last(w_last)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_FETCH;
    else
      state <= state_nxt;
  end

  // sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (set_ill) ill_q <= 1'b1;
      if (set_tmo) tmo_q <= 1'b1;
    end
  end

  // next-state and strobe decode
  always_comb begin
    state_nxt         = state;
    w_inc             = 1'b0;
    set_ill           = 1'b0;
    set_tmo           = 1'b0;
    bus.mem_req       = 1'b0;
    bus.pc_load       = 1'b0;
    bus.ir_load       = 1'b0;
    bus.st_mux_s      = 1'b0;
    bus.rf_load       = 1'b0;
    bus.flag_load     = 1'b0;
    bus.ld_mux_s      = 1'b0;
    bus.data_memo_str = 1'b0;
    bus.jump_select   = JS_PC1;
    if (run) begin
      unique case (state)
        ST_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_load = 1'b1;
            bus.pc_load = 1'b1;
            state_nxt   = ST_DECODE;
          end else begin
            w_inc = 1'b1;
            if (w_last) begin
              set_tmo   = 1'b1;
              state_nxt = ST_ERROR;
            end
          end
        end
        ST_DECODE: begin
          unique case (1'b1)
            op_bad: begin
              set_ill   = 1'b1;
              state_nxt = ST_ERROR;
            end
            d_exec:  state_nxt = ST_EXEC;
            d_mem:   state_nxt = ST_MEM;
            d_jump:  state_nxt = ST_JUMP;
            d_halt:  state_nxt = ST_HALT;
            default: state_nxt = ST_ERROR;
          endcase
        end
        ST_EXEC: begin
          bus.rf_load   = 1'b1;
          bus.flag_load = is_alu(op);
          state_nxt     = ST_FETCH;
        end
        ST_MEM: begin
          bus.mem_req = 1'b1;
          if (op == OP_ST) begin
            bus.st_mux_s      = 1'b1;
            bus.data_memo_str = 1'b1;
          end
          if (bus.mem_ready) begin
            if (op != OP_ST) begin
              bus.rf_load  = 1'b1;
              bus.ld_mux_s = 1'b1;
            end
            state_nxt = ST_FETCH;
          end else begin
            w_inc = 1'b1;
            if (w_last) begin
              set_tmo   = 1'b1;
              state_nxt = ST_ERROR;
            end
          end
        end
        ST_JUMP: begin
          bus.pc_load     = 1'b1;
          bus.jump_select = jsel_of(op);
          state_nxt       = ST_FETCH;
        end
        ST_HALT:  state_nxt = ST_HALT;
        ST_ERROR: state_nxt = ST_ERROR;
        default:  state_nxt = ST_ERROR;
      endcase
    end
  end

  assign w_clr = (state_nxt != state) &&
                 ((state_nxt == ST_FETCH) ||
                  (state_nxt == ST_MEM));

  assign bus.enable_registers = run &&
    (state != ST_HALT) && (state != ST_ERROR);
  assign bus.halted      = (state == ST_HALT) & ~rst;
  assign bus.illegal     = ill_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an
// instruction-level model queues per-cycle expected outputs.
module tb_multicycle_controller;

  localparam int OW  = 6;
  localparam int TW  = 4;
  localparam int TMO = 3;

  typedef struct packed {
    logic       mem_req;
    logic       ir_load;
    logic       pc_load;
    logic       st_mux_s;
    logic       rf_load;
    logic       flag_load;
    logic       ld_mux_s;
    logic       data_memo_str;
    logic [2:0] jump_select;
    logic       enable_registers;
    logic       halted;
    logic       illegal;
    logic       timeout_err;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OPCODE_W(OW)) bus();

  multicycle_controller #(
    .OPCODE_W   (OW),
    .TIMEOUT_W  (TW),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    m_halt, m_ill, m_tmo;

  function automatic obs_t base(input bit en);
    obs_t e;
    e = '0;
    e.halted      = m_halt;
    e.illegal     = m_ill;
    e.timeout_err = m_tmo;
    e.enable_registers = en && !(m_halt || m_ill || m_tmo);
    return e;
  endfunction

  // monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    obs_t a, e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.mem_req          = bus.mem_req;
      a.ir_load          = bus.ir_load;
      a.pc_load          = bus.pc_load;
      a.st_mux_s         = bus.st_mux_s;
      a.rf_load          = bus.rf_load;
      a.flag_load        = bus.flag_load;
      a.ld_mux_s         = bus.ld_mux_s;
      a.data_memo_str    = bus.data_memo_str;
      a.jump_select      = bus.jump_select;
      a.enable_registers = bus.enable_registers;
      a.halted           = bus.halted;
      a.illegal          = bus.illegal;
      a.timeout_err      = bus.timeout_err;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s @%0t: got %b want %b",
                 t, $time, a, e);
      end
    end
  end

  task automatic push(input obs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic dis(input int n);
    repeat (n) begin
      bus.enable    = 1'b0;
      bus.mem_ready = 1'($urandom);
      push(base(0), "disabled");
    end
  endtask

  task automatic cyc(input bit rdy, input obs_t e,
                     input string t);
    if ($urandom_range(0, 9) == 0)
      dis($urandom_range(1, 2));
    bus.enable    = 1'b1;
    bus.mem_ready = rdy;
    push(e, t);
  endtask

  task automatic tail(input int n, input string t);
    repeat (n) cyc(1'($urandom), base(1), t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable    = 1'b1;
    bus.mem_ready = 1'b1;
    push('0, "reset");
    push('0, "reset");
    rst   = 1'b0;
    m_halt = 1'b0;
    m_ill  = 1'b0;
    m_tmo  = 1'b0;
  endtask

  // one instruction at the behavioural level
  task automatic run_instr(input logic [OW-1:0] op,
                           input int fw, input int mw,
                           input int hold_dis);
    obs_t       e;
    logic [3:0] lo;
    bit         ill;
    bus.opcode = op;
    lo  = op[3:0];
    ill = (op >> 4) != 0;
    for (int i = 0; i < fw; i++) begin
      if (i == 1 && hold_dis > 0) dis(hold_dis);
      e = base(1);
      e.mem_req = 1'b1;
      cyc(1'b0, e, "fetch_wait");
      if (i + 1 == TMO) begin
        m_tmo = 1'b1;
        tail(4, "fetch_timeout");
        return;
      end
    end
    e = base(1);
    e.mem_req = 1'b1;
    e.ir_load = 1'b1;
    e.pc_load = 1'b1;
    cyc(1'b1, e, "fetch_ready");
    cyc(1'($urandom), base(1), "decode");
    if (ill) begin
      m_ill = 1'b1;
      tail(4, "illegal");
      return;
    end
    if (lo == 4'd15) begin
      m_halt = 1'b1;
      tail(12, "halt");
      return;
    end
    if (lo == 4'd8 || lo == 4'd9) begin
      for (int i = 0; i < mw; i++) begin
        e = base(1);
        e.mem_req = 1'b1;
        if (lo == 4'd9) begin
          e.st_mux_s      = 1'b1;
          e.data_memo_str = 1'b1;
        end
        cyc(1'b0, e, "mem_wait");
        if (i + 1 == TMO) begin
          m_tmo = 1'b1;
          tail(4, "mem_timeout");
          return;
        end
      end
      e = base(1);
      e.mem_req = 1'b1;
      if (lo == 4'd9) begin
        e.st_mux_s      = 1'b1;
        e.data_memo_str = 1'b1;
      end else begin
        e.rf_load  = 1'b1;
        e.ld_mux_s = 1'b1;
      end
      cyc(1'b1, e, "mem_ready");
    end else if (lo >= 4'd11) begin
      e = base(1);
      e.pc_load     = 1'b1;
      e.jump_select = 3'(lo - 4'd10);
      cyc(1'($urandom), e, "jump");
    end else begin
      e = base(1);
      e.rf_load   = 1'b1;
      e.flag_load = (lo < 4'd8);
      cyc(1'($urandom), e, "exec");
    end
  endtask

  // async reset pulse between edges while an LD waits in MEM
  task automatic mem_abort();
    obs_t e;
    bus.opcode = OW'(8);
    e = base(1);
    e.mem_req = 1'b1;
    e.ir_load = 1'b1;
    e.pc_load = 1'b1;
    cyc(1'b1, e, "abort_fetch");
    cyc(1'b0, base(1), "abort_decode");
    e = base(1);
    e.mem_req = 1'b1;
    cyc(1'b0, e, "abort_mem_wait");
    cyc(1'b0, e, "abort_mem_wait");
    bus.enable    = 1'b1;
    bus.mem_ready = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back("abort_mem_last");
    #5;
    bus.enable = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_halt = 1'b0;
    m_ill  = 1'b0;
    m_tmo  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.enable    = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = '0;
    @(posedge clk);
    #1;
    do_reset();
    run_instr(OW'(0), 0, 0, 0);
    run_instr(OW'(8), 0, 2, 0);
    run_instr(OW'(9), 1, 2, 0);
    run_instr(OW'(10), 0, 0, 0);
    for (int j = 11; j <= 14; j++)
      run_instr(OW'(j), 0, 0, 0);
    run_instr(OW'(3), 2, 0, 3);
    for (int k = 0; k < 60; k++)
      run_instr(OW'($urandom_range(0, 14)),
                $urandom_range(0, 2),
                $urandom_range(0, 2), 0);
    run_instr(OW'(1), 3, 0, 0);
    do_reset();
    run_instr(OW'(1), 2, 0, 0);
    run_instr(OW'(8), 0, 3, 0);
    do_reset();
    run_instr(OW'(9), 0, 3, 0);
    do_reset();
    run_instr(6'b010000, 0, 0, 0);
    do_reset();
    run_instr(6'b100111, 1, 0, 0);
    do_reset();
    run_instr(OW'(15), 1, 0, 0);
    do_reset();
    run_instr(OW'(2), 0, 0, 0);
    mem_abort();
    run_instr(OW'(0), 2, 0, 0);
    run_instr(OW'(8), 2, 2, 0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle CPU control unit driving the datapath's PC, IR, register file, flag register, load/store muxes and data memory. It is the next generation of the project's controller. Its additions:
- a registered FSM with asynchronous reset;
- a `mem_req`/`mem_ready` handshake for instruction fetch and data access, so memories may take any number of cycles;
- a programmable wait timeout;
- sticky halt and error states.

## Interface
Parameters:
- `OPCODE_W`, default 4: opcode width, must be ≥4. Any nonzero bit above bit [3] makes the opcode illegal.
- `TIMEOUT_W`, default 4: width of the wait counter.
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles before an error. A value of 0 disables the timeout. Must be < 2^TIMEOUT_W.

Ports (clock and reset first):
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `enable`, in, 1: run enable. When low, the FSM freezes.
- `opcode`, in, OPCODE_W: instruction opcode from IR, valid from DECODE onward.
- `mem_ready`, in, 1: memory completes the current request this cycle.
- `mem_req`, out, 1: memory request. Instruction fetch in FETCH, data access in MEM.
- `enable_registers`, out, 1: datapath register enable.
- `pc_load`, out, 1: PC load strobe.
- `ir_load`, out, 1: IR load strobe.
- `st_mux_s`, out, 1: address/data mux. 0 selects the fetch/load address, 1 selects the store path.
- `rf_load`, out, 1: register file write strobe.
- `flag_load`, out, 1: flag register load strobe.
- `ld_mux_s`, out, 1: RF write source. 0 = ALU, 1 = memory.
- `data_memo_str`, out, 1: data memory store strobe.
- `jump_select`, out, 3: PC source select.
- `halted`, out, 1: sticky; high in HALT.
- `illegal`, out, 1: sticky; high after an illegal opcode.
- `timeout_err`, out, 1: sticky; high after a memory timeout.

## Operation
Opcode map (low 4 bits):
- 0000–0111: ALU operations (ADD, SUB, AND, OR, XOR, NOT, LSL, LSR).
- 1000: LD. 1001: ST. 1010: MOV.
- 1011: JMP. 1100: JZ. 1101: JNZ. 1110: JC.
- 1111: HALT.

`jump_select` codes:
- 000 = PC+1, 001 = JMP, 010 = JZ, 011 = JNZ, 100 = JC.
- The datapath evaluates the flags; the controller always strobes `pc_load` in JUMP.

States and outputs (all strobes are 0 unless listed):
- **FETCH**: `mem_req`=1.
  - If `mem_ready`: `ir_load`=1, `pc_load`=1, `jump_select`=000, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**: no strobes. Next state by opcode:
  - ALU or MOV → EXEC.
  - LD or ST → MEM.
  - Jumps → JUMP.
  - 1111 → HALT.
  - Upper bits nonzero → ERROR, with `illegal` set.
- **EXEC**: `rf_load`=1, `ld_mux_s`=0. `flag_load`=1 for ALU ops, 0 for MOV. Then go to FETCH.
- **MEM, LD**: `mem_req`=1, `st_mux_s`=0. On `mem_ready`: `rf_load`=1, `ld_mux_s`=1, then go to FETCH.
- **MEM, ST**: `mem_req`=1, `st_mux_s`=1, `data_memo_str`=1, held until `mem_ready`, then go to FETCH.
- **JUMP**: `pc_load`=1, `jump_select` = code for the opcode. Then go to FETCH.
- **HALT**: `halted`=1. Terminal until `rst`.
- **ERROR**: terminal until `rst`.

`enable_registers` = `enable` AND NOT (HALT or ERROR) AND NOT `rst`.

Enable low:
- State and wait counter hold.
- All strobes, including `mem_req`, are forced to 0.
- The sticky flags hold.
- When `enable` returns high, the request in FETCH or MEM is reissued.

Wait counter:
- Cleared on entry to FETCH or MEM.
- Increments on each enabled cycle with `mem_req`=1 and `mem_ready`=0.
- When it reaches MEM_TIMEOUT while still waiting, the next state is ERROR and `timeout_err` is set.
- If `mem_ready` arrives in the same cycle as the final count, `mem_ready` wins.

## Timing
- Outputs are decoded from the registered state plus `opcode`, `mem_ready` and `enable`; no added latency.
- `mem_ready` is accepted in the same cycle as `mem_req`.
- Reset: state = FETCH, counter = 0, sticky flags = 0, and all outputs are 0 while `rst` is high. Reset is asynchronous and also aborts any pending request.
- First `mem_req` appears in the first cycle after `rst` falls with `enable`=1.
- Zero-wait latencies:
  - ALU or MOV: 3 cycles (FETCH, DECODE, EXEC).
  - LD or ST: 3 cycles (FETCH, DECODE, MEM).
  - Jump: 3 cycles (FETCH, DECODE, JUMP).
  - HALT: reached 2 cycles after fetch start.
- Each wait cycle adds 1 cycle to FETCH or MEM.

## Structure
- **`controller_pkg`** (shared package) holds:
  - the state encoding as a 3-bit enum: FETCH, DECODE, EXEC, MEM, JUMP, HALT, ERROR;
  - the opcode constants;
  - the `jump_select` code constants.
- **`ctrl_wait_timer`** is a natural sub-module: the wait counter with clear, increment and expiry compare against MEM_TIMEOUT, with MEM_TIMEOUT=0 disabling expiry.
- Top level contains the state register, next-state logic and output decode.

## Test plan
- Reset, then zero-wait ADD (0000) → FETCH: `ir_load`=`pc_load`=1. DECODE: no strobes. EXEC: `rf_load`=`flag_load`=1, `ld_mux_s`=0. Back to FETCH at cycle 3.
- LD (1000) with `mem_ready` delayed 2 cycles in MEM → `mem_req` high for 3 cycles; `rf_load`=1 and `ld_mux_s`=1 only in the ready cycle. ST (1001) → `data_memo_str`=`st_mux_s`=1 held until ready.
- Jumps 1011/1100/1101/1110 → JUMP asserts `pc_load`=1 with `jump_select` = 001/010/011/100 respectively.
- MEM_TIMEOUT=3, `mem_ready` held low in FETCH → after 3 wait cycles: ERROR, `timeout_err`=1, `enable_registers`=0. Ready on the 3rd cycle instead → proceeds to DECODE with no error.
- OPCODE_W=6 with opcode 6'b010000 → ERROR, `illegal`=1. HALT (1111) → `halted`=1, stays in HALT for 10+ cycles.
- `enable` dropped mid-FETCH wait, then async `rst` pulse mid-MEM → all strobes 0 while disabled and the counter is frozen; after reset: state FETCH, flags cleared.
